// File: rtl/pong_frame_scheduler.sv
// pong_frame_scheduler
//   Once per video frame (on frameStrobe, during vertical blanking) steps a
//   short sequence that moves both paddles, advances the ball, resolves wall
//   and paddle collisions and keeps score. All arithmetic runs on shadow
//   registers; the published coordinates change only in the COMMIT cycle, so
//   the pixel renderer never sees a half-updated frame.
//
// Ports
//   pixelClock            in   pixel clock, all logic on rising edge
//   reset                 in   asynchronous, active-high
//   frameStrobe           in   one-cycle pulse at start of vertical blanking
//   btnLUp/btnLDn         in   left paddle command levels
//   btnRUp/btnRDn         in   right paddle command levels
//   serve                 in   one-cycle pulse, launches the ball
//   paddleLY/paddleRY     out  paddle top edges
//   ballX/ballY           out  ball top-left corner
//   scoreL/scoreR         out  scores 0..WIN_SCORE
//   running               out  ball in play
//   gameOver              out  a score reached WIN_SCORE (held until reset)
//   busy                  out  update sequence in progress
//   overrun               out  sticky; frameStrobe arrived while busy
module pong_frame_scheduler #(
  parameter int unsigned H_VISIBLE   = 1024,
  parameter int unsigned V_VISIBLE   = 768,
  parameter int unsigned BORDER      = 16,
  parameter int unsigned PADDLE_H    = 96,
  parameter int unsigned PADDLE_W    = 16,
  parameter int unsigned BALL_SIZE   = 16,
  parameter int unsigned PADDLE_XL   = 32,
  parameter int unsigned PADDLE_XR   = 976,
  parameter int unsigned PADDLE_STEP = 4,
  parameter int unsigned BALL_STEP   = 2,
  parameter int unsigned WIN_SCORE   = 9
) (
  input  logic       pixelClock,
  input  logic       reset,
  input  logic       frameStrobe,
  input  logic       btnLUp,
  input  logic       btnLDn,
  input  logic       btnRUp,
  input  logic       btnRDn,
  input  logic       serve,
  output logic [9:0] paddleLY,
  output logic [9:0] paddleRY,
  output logic [9:0] ballX,
  output logic [9:0] ballY,
  output logic [3:0] scoreL,
  output logic [3:0] scoreR,
  output logic       running,
  output logic       gameOver,
  output logic       busy,
  output logic       overrun
);

  // Positions (10-bit) and 11-bit constants for edge sums that must not wrap
  localparam logic [9:0]  PADDLE_Y0  = 10'((V_VISIBLE - PADDLE_H) / 2);
  localparam logic [9:0]  BALL_X0    = 10'((H_VISIBLE - BALL_SIZE) / 2);
  localparam logic [9:0]  BALL_Y0    = 10'((V_VISIBLE - BALL_SIZE) / 2);
  localparam logic [9:0]  BALL_Y_MIN = 10'(BORDER);
  localparam logic [9:0]  BALL_Y_MAX = 10'(V_VISIBLE - BORDER - BALL_SIZE);
  localparam logic [9:0]  HIT_XL     = 10'(PADDLE_XL + PADDLE_W);
  localparam logic [9:0]  HIT_XR_POS = 10'(PADDLE_XR - BALL_SIZE);
  localparam logic [9:0]  MISS_XL    = 10'(BORDER);
  localparam logic [9:0]  B_STEP     = 10'(BALL_STEP);
  localparam logic [10:0] PADDLE_MIN = 11'(BORDER);
  localparam logic [10:0] PADDLE_MAX = 11'(V_VISIBLE - BORDER - PADDLE_H);
  localparam logic [10:0] P_STEP     = 11'(PADDLE_STEP);
  localparam logic [10:0] BALL_W     = 11'(BALL_SIZE);
  localparam logic [10:0] PAD_H      = 11'(PADDLE_H);
  localparam logic [10:0] XR_EDGE    = 11'(PADDLE_XR);
  localparam logic [10:0] MISS_XR    = 11'(H_VISIBLE - BORDER);
  localparam logic [3:0]  WIN        = 4'(WIN_SCORE);

  typedef enum logic [2:0] {WAIT, PADDLES, BALL, WALLS, HITS, COMMIT} state_t;

  state_t state, stateNext;

  // Shadow (working) copies of the game state
  logic [9:0] shPaddleLY, shPaddleRY, shBallX, shBallY;
  logic [3:0] shScoreL, shScoreR;
  logic       shDx, shDy, shRunning, shGameOver;

  // Decoded control
  logic accept, commitEn, busyNext, overrunSet;

  // Datapath helpers
  logic [9:0]  plyNext, pryNext, bxMoved, byMoved;
  logic [10:0] bx11, by11, ply11, pry11, ballBottom, ballRight;
  logic        overlapL, overlapR, hitL, missL, hitR, missR;
  logic [3:0]  scoreLInc, scoreRInc;

  function automatic logic [9:0] movePaddle(input logic [9:0] y, input logic up,
                                            input logic dn);
    logic [10:0] t;
    t = {1'b0, y};
    if (up && !dn)
      t = (t < PADDLE_MIN + P_STEP) ? PADDLE_MIN : t - P_STEP;
    else if (dn && !up)
      t = (t + P_STEP > PADDLE_MAX) ? PADDLE_MAX : t + P_STEP;
    return t[9:0];
  endfunction

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge pixelClock or posedge reset) begin
    if (reset) state <= WAIT;
    else       state <= stateNext;
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    stateNext = state;
    case (state)
      WAIT:    if (accept) stateNext = PADDLES;
      PADDLES: stateNext = BALL;
      BALL:    stateNext = WALLS;
      WALLS:   stateNext = HITS;
      HITS:    stateNext = COMMIT;
      COMMIT:  stateNext = WAIT;
      default: stateNext = WAIT;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  // busy is registered: set on the accepting edge and held through the COMMIT
  // edge, so it drops one cycle after the sequence returns to WAIT. A strobe
  // in that tail cycle is still treated as an overrun.
  always_comb begin
    accept     = (state == WAIT) && frameStrobe && !busy;
    commitEn   = (state == COMMIT);
    busyNext   = accept || (state != WAIT);
    overrunSet = frameStrobe && busy;
  end

  // ---------------------------------------------------------------- datapath
  always_comb begin
    plyNext    = movePaddle(shPaddleLY, btnLUp, btnLDn);
    pryNext    = movePaddle(shPaddleRY, btnRUp, btnRDn);
    bxMoved    = shDx ? shBallX + B_STEP : shBallX - B_STEP;
    byMoved    = shDy ? shBallY + B_STEP : shBallY - B_STEP;
    bx11       = {1'b0, shBallX};
    by11       = {1'b0, shBallY};
    ply11      = {1'b0, shPaddleLY};
    pry11      = {1'b0, shPaddleRY};
    ballBottom = by11 + BALL_W;
    ballRight  = bx11 + BALL_W;
    overlapL   = (ballBottom > ply11) && (by11 < ply11 + PAD_H);
    overlapR   = (ballBottom > pry11) && (by11 < pry11 + PAD_H);
    // a hit takes priority over a miss on the same side
    hitL       = !shDx && (shBallX <= HIT_XL) && overlapL;
    missL      = !shDx && !hitL && (shBallX <= MISS_XL);
    hitR       = shDx && (ballRight >= XR_EDGE) && overlapR;
    missR      = shDx && !hitR && (ballRight >= MISS_XR);
    scoreLInc  = shScoreL + 4'd1;
    scoreRInc  = shScoreR + 4'd1;
  end

  always_ff @(posedge pixelClock or posedge reset) begin
    if (reset) begin
      shPaddleLY <= PADDLE_Y0;
      shPaddleRY <= PADDLE_Y0;
      shBallX    <= BALL_X0;
      shBallY    <= BALL_Y0;
      shScoreL   <= '0;
      shScoreR   <= '0;
      shDx       <= 1'b1;
      shDy       <= 1'b1;
      shRunning  <= 1'b0;
      shGameOver <= 1'b0;
    end else begin
      // serve may arrive in any state; the ball first moves in the next BALL
      if (serve && !shRunning && !shGameOver) shRunning <= 1'b1;
      case (state)
        PADDLES: begin
          shPaddleLY <= plyNext;
          shPaddleRY <= pryNext;
        end
        BALL: begin
          if (shRunning) begin
            shBallX <= bxMoved;
            shBallY <= byMoved;
          end else begin
            shBallX <= BALL_X0;
            shBallY <= BALL_Y0;
          end
        end
        WALLS: begin
          if (shBallY <= BALL_Y_MIN) begin
            shBallY <= BALL_Y_MIN;
            shDy    <= 1'b1;
          end else if (shBallY >= BALL_Y_MAX) begin
            shBallY <= BALL_Y_MAX;
            shDy    <= 1'b0;
          end
        end
        HITS: begin
          if (shRunning) begin
            if (hitL) begin
              shBallX <= HIT_XL;
              shDx    <= 1'b1;
            end else if (missL) begin
              shScoreR  <= scoreRInc;
              shRunning <= 1'b0;
              shBallX   <= BALL_X0;
              shBallY   <= BALL_Y0;
              shDx      <= 1'b1;
              if (scoreRInc == WIN) shGameOver <= 1'b1;
            end else if (hitR) begin
              shBallX <= HIT_XR_POS;
              shDx    <= 1'b0;
            end else if (missR) begin
              shScoreL  <= scoreLInc;
              shRunning <= 1'b0;
              shBallX   <= BALL_X0;
              shBallY   <= BALL_Y0;
              shDx      <= 1'b0;
              if (scoreLInc == WIN) shGameOver <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------- published state
  always_ff @(posedge pixelClock or posedge reset) begin
    if (reset) begin
      paddleLY <= PADDLE_Y0;
      paddleRY <= PADDLE_Y0;
      ballX    <= BALL_X0;
      ballY    <= BALL_Y0;
      scoreL   <= '0;
      scoreR   <= '0;
      running  <= 1'b0;
      gameOver <= 1'b0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      busy <= busyNext;
      if (overrunSet) overrun <= 1'b1;
      if (commitEn) begin
        paddleLY <= shPaddleLY;
        paddleRY <= shPaddleRY;
        ballX    <= shBallX;
        ballY    <= shBallY;
        scoreL   <= shScoreL;
        scoreR   <= shScoreR;
        running  <= shRunning;
        gameOver <= shGameOver;
      end
    end
  end

endmodule
